// File: rtl/button_bounce_gen.sv
// Contact-bounce emulator: turns a clean level change into an LFSR-driven toggle burst
// of BOUNCE_CYCLES cycles, then settles to the new level. enable=0 gives a registered pass-through.
module button_bounce_gen #(
    parameter int unsigned BOUNCE_CYCLES = 20,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clean,
    input  logic       enable,
    output logic       noisy,
    output logic       bouncing,
    output logic       settled_pulse,
    output logic [7:0] bounce_count
);

    localparam int CNT_W = $clog2(BOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        BOUNCE
    } state_t;

    state_t           state, state_d;
    logic             level, level_d;
    logic             target, target_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [15:0]      lfsr;
    logic             noisy_d;
    logic             pulse_d;
    logic [7:0]       count_d;
    logic             lfsr_fb;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign bouncing = (state == BOUNCE);

    // The toggle decision below always sees the pre-advance lfsr[0].
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            level         <= 1'b0;
            target        <= 1'b0;
            cnt           <= '0;
            noisy         <= 1'b0;
            settled_pulse <= 1'b0;
            bounce_count  <= 8'd0;
        end else begin
            state         <= state_d;
            level         <= level_d;
            target        <= target_d;
            cnt           <= cnt_d;
            noisy         <= noisy_d;
            settled_pulse <= pulse_d;
            bounce_count  <= count_d;
        end
    end

    always_comb begin
        state_d  = state;
        level_d  = level;
        target_d = target;
        cnt_d    = cnt;
        noisy_d  = noisy;
        pulse_d  = 1'b0;
        count_d  = bounce_count;

        if (!enable) begin
            // Pass-through; also aborts any open window without a settle pulse.
            state_d = IDLE;
            noisy_d = clean;
            level_d = clean;
        end else begin
            unique case (state)
                IDLE: begin
                    noisy_d = level;
                    if (clean != level) begin
                        state_d  = BOUNCE;
                        target_d = clean;
                        noisy_d  = clean;
                        cnt_d    = CNT_LOAD;
                        count_d  = 8'd1;
                    end
                end
                BOUNCE: begin
                    if (clean != target) begin
                        target_d = clean;
                        noisy_d  = clean;
                        cnt_d    = CNT_LOAD;
                        if (clean != noisy) begin
                            count_d = sat_inc(bounce_count);
                        end
                    end else if (cnt != '0) begin
                        cnt_d = cnt - CNT_ONE;
                        if (lfsr[0]) begin
                            noisy_d = ~noisy;
                            count_d = sat_inc(bounce_count);
                        end
                    end else begin
                        noisy_d = target;
                        level_d = target;
                        state_d = IDLE;
                        pulse_d = 1'b1;
                        if (noisy != target) begin
                            count_d = sat_inc(bounce_count);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_bounce_gen.sv
// Scoreboard bench for button_bounce_gen: a behavioural model predicts every output cycle,
// a monitor compares, and directed scenarios check window length, pulses and aborts.
module tb_button_bounce_gen;

    localparam int          BC   = 20;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clean = 1'b0;
    logic       enable = 1'b1;
    logic       noisy;
    logic       bouncing;
    logic       settled_pulse;
    logic [7:0] bounce_count;

    button_bounce_gen #(.BOUNCE_CYCLES(BC), .SEED(SEED)) dut (
        .clk          (clk),
        .reset        (reset),
        .clean        (clean),
        .enable       (enable),
        .noisy        (noisy),
        .bouncing     (bouncing),
        .settled_pulse(settled_pulse),
        .bounce_count (bounce_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       noisy;
        logic       bouncing;
        logic       pulse;
        logic [7:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   obs_hi = 0;
    int   obs_pulse = 0;

    // Reference model state: window is tracked as "cycles left" rather than a counter register.
    bit          m_level, m_target, m_noisy, m_busy, m_pulse;
    int          m_left, m_count;
    logic [15:0] m_lfsr = SEED;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic bump();
        m_count = (m_count < 255) ? m_count + 1 : 255;
    endtask

    task automatic model_step(input bit r, input bit c, input bit e);
        bit t;
        exp_t x;
        if (r) begin
            m_level = 0; m_target = 0; m_noisy = 0; m_busy = 0;
            m_left = 0; m_count = 0; m_pulse = 0; m_lfsr = SEED;
        end else begin
            t = m_lfsr[0];
            m_lfsr = lfsr_next(m_lfsr);
            m_pulse = 0;
            if (!e) begin
                m_busy = 0; m_noisy = c; m_level = c;
            end else if (!m_busy) begin
                if (c != m_level) begin
                    m_busy = 1; m_target = c; m_noisy = c; m_left = BC - 1; m_count = 1;
                end
            end else if (c != m_target) begin
                if (c != m_noisy) bump();
                m_target = c; m_noisy = c; m_left = BC - 1;
            end else if (m_left > 0) begin
                if (t) begin
                    m_noisy = !m_noisy;
                    bump();
                end
                m_left--;
            end else begin
                if (m_noisy != m_target) bump();
                m_noisy = m_target; m_level = m_target; m_busy = 0; m_pulse = 1;
            end
        end
        x.noisy    = m_noisy;
        x.bouncing = m_busy;
        x.pulse    = m_pulse;
        x.count    = 8'(m_count);
        exp_q.push_back(x);
    endtask

    // Inputs change on negedge; the expected post-edge outputs are queued for the monitor.
    task automatic step(input bit r, input bit c, input bit e);
        reset  = r;
        clean  = c;
        enable = e;
        model_step(r, c, e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (bouncing === 1'b1) obs_hi++;
        if (settled_pulse === 1'b1) obs_pulse++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("noisy", int'(noisy), int'(e.noisy));
            check("bouncing", int'(bouncing), int'(e.bouncing));
            check("settled_pulse", int'(settled_pulse), int'(e.pulse));
            check("bounce_count", int'(bounce_count), int'(e.count));
        end
    end

    initial begin
        int hi0, p0;
        bit c;
        @(negedge clk);

        // Reset held for three cycles with clean low.
        for (int i = 0; i < 3; i++) step(1, 0, 1);

        // Single undisturbed window.
        hi0 = obs_hi; p0 = obs_pulse;
        for (int i = 0; i < 25; i++) step(0, 1, 1);
        check("t2_window_len", obs_hi - hi0, BC);
        check("t2_pulses", obs_pulse - p0, 1);
        check("t2_noisy_final", int'(noisy), 1);
        check("t2_count_odd", int'(bounce_count) % 2, 1);

        // Random clean changes, mostly enabled.
        c = 1;
        for (int i = 0; i < 50; i++) begin
            int hold;
            bit en;
            c    = !c;
            hold = $urandom_range(1, 30);
            en   = ($urandom_range(0, 7) != 0);
            for (int j = 0; j < hold; j++) step(0, c, en);
        end
        for (int i = 0; i < 25; i++) step(0, 0, 1);

        // Window restarted by clean returning low on window cycle 10.
        hi0 = obs_hi; p0 = obs_pulse;
        for (int i = 0; i < 10; i++) step(0, 1, 1);
        for (int i = 0; i < 25; i++) step(0, 0, 1);
        check("t4_window_len", obs_hi - hi0, 30);
        check("t4_pulses", obs_pulse - p0, 1);
        check("t4_noisy_final", int'(noisy), 0);

        // Pass-through mode, then enable dropped on window cycle 5.
        hi0 = obs_hi;
        for (int i = 0; i < 12; i++) step(0, 1'($urandom_range(0, 1)), 0);
        check("t5_no_bounce", obs_hi - hi0, 0);
        step(0, 0, 0);
        hi0 = obs_hi; p0 = obs_pulse;
        for (int i = 0; i < 5; i++) step(0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        check("t5_abort_len", obs_hi - hi0, 5);
        check("t5_abort_pulses", obs_pulse - p0, 0);
        check("t5_noisy_pass", int'(noisy), 1);

        // Reset pulsed on window cycle 7, then a fresh window with clean held high.
        for (int i = 0; i < 25; i++) step(0, 0, 1);
        hi0 = obs_hi; p0 = obs_pulse;
        for (int i = 0; i < 7; i++) step(0, 1, 1);
        step(1, 1, 1);
        check("t6_after_reset_bouncing", int'(bouncing), 0);
        check("t6_after_reset_count", int'(bounce_count), 0);
        for (int i = 0; i < 25; i++) step(0, 1, 1);
        check("t6_total_hi", obs_hi - hi0, 7 + BC);
        check("t6_pulses", obs_pulse - p0, 1);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
